// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle main control FSM for the 32-bit MIPS-subset core
//
// Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type,
// beq, addi and j by driving datapath enables, mux selects and aluop.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   synchronous, active-high; forces every output to 0
//   op[5:0]    in   opcode, instr[31:26]; sampled only in DECODE and MEMADR
//   pcwrite    out  unconditional PC write enable
//   branch     out  conditional PC write (ANDed with zero in the datapath)
//   iord       out  memory address mux: 0 = PC, 1 = ALUOut
//   memwrite   out  data memory write enable
//   irwrite    out  instruction register load
//   memtoreg   out  writeback mux: 0 = ALUOut, 1 = Data
//   regdst     out  destination register: 0 = rt, 1 = rd
//   regwrite   out  register file write enable
//   alusrca    out  ALU A mux: 0 = PC, 1 = A
//   alusrcb    out  ALU B mux: 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   pcsrc      out  PC mux: 00 ALUResult, 01 ALUOut, 10 jump target
//   aluop      out  to aludec: 00 add, 01 subtract, 10 decode funct
//   illegal    out  high during a DECODE cycle that sees an unsupported op
//   state      out  current state encoding (debug)
//
// ILLEGAL_TRAP: 0 = unknown opcode acts as a nop, 1 = park in HALT until reset.

module mainfsm #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q;
  state_t state_d;
  logic   op_known;

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_known = 1'b1;
      default:                                      op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      // 13-15 are never entered normally; recover to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs decode from the registered state only (illegal also looks at op).
  // Holding reset gates everything to 0 so no enable leaks out while the
  // state register is still carrying an abandoned instruction.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    state    = 4'd0;
    if (!reset) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          alusrcb = 2'b01;
          irwrite = 1'b1;
          pcwrite = 1'b1;
        end
        S_DECODE: begin
          // Branch target PC+4 + (SignImm<<2) is precomputed into ALUOut.
          alusrcb = 2'b11;
          illegal = ~op_known;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          iord = 1'b1;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: begin
          regwrite = 1'b1;
        end
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: begin
          // HALT and unused encodings drive nothing.
        end
      endcase
    end
  end

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
- Multicycle main control FSM for the 32-bit MIPS-subset core.
- Takes the instruction opcode from the instruction register.
- Sequences fetch, decode, execute, memory and writeback by driving datapath enables, mux selects and the 2-bit aluop.
- aluop feeds aludec; encoding: 00 add, 01 subtract, 10 decode funct.

Parameters:
ILLEGAL_TRAP, 0, 0: an unknown opcode in DECODE returns to FETCH (acts as a nop). 1: the FSM enters HALT and stays there until reset.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
op  input  6  opcode field, instr[31:26], held stable by the datapath after FETCH
pcwrite  output  1  unconditional PC write enable
branch  output  1  conditional PC write; datapath ANDs it with zero
iord  output  1  memory address mux: 0 = PC, 1 = ALUOut
memwrite  output  1  data memory write enable
irwrite  output  1  instruction register load
memtoreg  output  1  writeback mux: 0 = ALUOut, 1 = Data
regdst  output  1  destination register: 0 = rt, 1 = rd
regwrite  output  1  register file write enable
alusrca  output  1  ALU A mux: 0 = PC, 1 = A
alusrcb  output  2  ALU B mux: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  output  2  PC mux: 00 = ALUResult, 01 = ALUOut, 10 = jump target
aluop  output  2  to aludec
illegal  output  1  high during the DECODE cycle that sees an unsupported opcode
state  output  4  current state encoding, for debug

Behaviour:
- Moore machine. All outputs are combinational from state only; illegal is the one exception and is also a function of op.
- Outputs not listed for a state are 0.
- Reset: at a rising clk edge with reset=1, state <= FETCH (0).
- While reset=1, every output is forced to 0 combinationally, including state=0.
- Reset mid-instruction abandons the instruction; no enable is asserted after reset is sampled.
- State encodings and outputs:
  - FETCH=0: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE=1: alusrca=0, alusrcb=11, aluop=00 (branch target computed into ALUOut).
  - MEMADR=2: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD=3: iord=1.
  - MEMWB=4: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR=5: iord=1, memwrite=1.
  - EXECUTE=6: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB=7: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH=8: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIEX=9: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB=10: regdst=0, memtoreg=0, regwrite=1.
  - JUMP=11: pcsrc=10, pcwrite=1.
  - HALT=12: all outputs 0.
  - Encodings 13-15: unreachable; if entered, all outputs 0 and next state is FETCH.
- Transitions (one state per clock):
  - FETCH -> DECODE.
  - DECODE by op:
    - 100011 lw / 101011 sw -> MEMADR.
    - 000000 R-type -> EXECUTE.
    - 000100 beq -> BRANCH.
    - 001000 addi -> ADDIEX.
    - 000010 j -> JUMP.
    - any other op -> FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1), with illegal=1 for that cycle.
  - MEMADR -> MEMRD if op=lw, otherwise MEMWR.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
  - HALT -> HALT.
- Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2 (trap off).
- op is sampled only in DECODE and MEMADR; op changes in other states have no effect.
- pcwrite and branch are never high in the same cycle. regwrite and memwrite are never high in the same cycle.

Test Plan:
- reset=1 for 2 cycles with op=100011 -> all outputs 0, state=0. First cycle after release: state=0, irwrite=1, pcwrite=1, alusrcb=01.
- lw (op=100011) -> state sequence 0,1,2,3,4,0. In state 4: regwrite=1, memtoreg=1, regdst=0. memwrite stays 0 throughout.
- sw (op=101011) -> sequence 0,1,2,5,0. memwrite=1 only in state 5, with iord=1. regwrite stays 0.
- R-type (op=000000) then beq (op=000100) -> state 6 has aluop=10; state 7 has regdst=1, regwrite=1. Then sequence 0,1,8 with aluop=01, branch=1, pcsrc=01.
- addi (op=001000) then j (op=000010) -> sequence 0,1,9,10,0,1,11,0. pcsrc=10 and pcwrite=1 in state 11.
- op=111111:
  - ILLEGAL_TRAP=0 -> illegal=1 in state 1, next state 0.
  - ILLEGAL_TRAP=1 -> state 12 held for 10 cycles with all outputs 0. Reset returns the FSM to 0.
  - Also: assert reset while in state 3 -> next state 0, and no regwrite is ever asserted.
